// File: rtl/rx_fifo.sv
// Byte receive queue, first-word-fall-through: a rising edge of in_valid stores one byte, visible on dout next cycle.
// Consumer backpressure via dout_ready; pushes into a full queue without a same-cycle pop are dropped and flagged.
module rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic [7:0]               dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          in_valid_q;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          drop;

  assign dout_valid = (count != '0);
  assign full       = (count == FULL_CNT);
  assign dout       = mem[rd_ptr];

  // A held in_valid level counts as one byte; only the rising edge pushes.
  assign push  = in_valid & ~in_valid_q;
  assign pop   = dout_valid & dout_ready;
  // A same-cycle pop frees the slot, so a full queue still accepts the byte.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_valid_q <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      in_valid_q <= in_valid;
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (ovf_clr)   overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo: reset, single byte, fill/overflow/drain, full push+pop, streaming wrap, reset corner cases.
module tb_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       ovf_clr;

  int n_chk  = 0;
  int n_pass = 0;

  rx_fifo #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    dout_ready = 1'b0;
    ovf_clr    = 1'b0;
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_dvld", dout_valid, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();

    // Level held for two cycles writes a single byte.
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    check("s1_count", count, 1);
    check("s1_dvld", dout_valid, 1);
    check("s1_dout", dout, 8'h55);
    tick();
    check("s1_held_count", count, 1);
    in_valid   = 1'b0;
    dout_ready = 1'b1;
    tick();
    check("s1_pop_count", count, 0);
    check("s1_pop_dvld", dout_valid, 0);
    dout_ready = 1'b0;

    // Fill to DEPTH, then a dropped 17th byte.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    check("fill_ovf", overflow, 0);
    push_byte(8'hAA);
    check("drop_ovf", overflow, 1);
    check("drop_count", count, 16);
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_dout", dout, i);
      tick();
    end
    dout_ready = 1'b0;
    check("drain_count", count, 0);
    check("drain_dvld", dout_valid, 0);
    check("drain_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_ovf", overflow, 0);

    // Full queue: push and pop in the same cycle.
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    check("f2_full", full, 1);
    in_valid   = 1'b1;
    in_data    = 8'hBB;
    dout_ready = 1'b1;
    tick();
    in_valid   = 1'b0;
    dout_ready = 1'b0;
    check("pp_count", count, 16);
    check("pp_ovf", overflow, 0);
    check("pp_head", dout, 8'h11);
    tick();

    // Set overflow, then clear it in the same cycle as another dropped push.
    push_byte(8'hCC);
    check("ovf_set", overflow, 1);
    in_valid = 1'b1;
    in_data  = 8'hDD;
    ovf_clr  = 1'b1;
    tick();
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    check("clr_prio_ovf", overflow, 0);
    check("clr_prio_count", count, 16);
    tick();
    dout_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check("d2_dout", dout, 8'h10 + i);
      tick();
    end
    check("d2_last", dout, 8'hBB);
    tick();
    dout_ready = 1'b0;
    check("d2_count", count, 0);

    // Streaming across pointer wrap with the consumer always ready.
    dout_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h80 + i);
      tick();
      check("st_dout", dout, 8'h80 + i);
      check("st_count1", count, 1);
      in_valid = 1'b0;
      tick();
      check("st_count0", count, 0);
    end
    dout_ready = 1'b0;

    // Reset mid-stream discards queued bytes immediately.
    for (int i = 0; i < 5; i++) push_byte(8'(8'h60 + i));
    check("mid_count5", count, 5);
    rst = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_dvld", dout_valid, 0);

    // in_valid high across reset release must not write.
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("held_rel_count", count, 0);
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    check("rel_edge_count", count, 1);
    check("rel_edge_dout", dout, 8'h77);
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of byte entries; legal values are powers of two from 2 to 256.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  byte-available level from the receiver; may stay high for more than one cycle per byte.
REQ-005 SHALL have port in_data  input  8  received byte; stable whenever in_valid is high.
REQ-006 SHALL have port dout  output  8  head-of-queue byte (first-word-fall-through).
REQ-007 SHALL have port dout_valid  output  1  high when the queue is not empty.
REQ-008 SHALL have port dout_ready  input  1  consumer accepts dout this cycle.
REQ-009 SHALL have port count  output  clog2(DEPTH)+1  number of stored bytes.
REQ-010 SHALL have port full  output  1  high when count == DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky flag; set when a byte was dropped.
REQ-012 SHALL have port ovf_clr  input  1  single-cycle request to clear overflow.

Function
REQ-013 SHALL register in_valid into in_valid_q each cycle and define push = in_valid & ~in_valid_q (rising edge only), so a held level writes exactly one byte.
REQ-014 SHALL define pop = dout_valid & dout_ready; a pop while empty has no effect.
REQ-015 SHALL, on push with count < DEPTH, write in_data at wr_ptr, increment wr_ptr modulo DEPTH and increment count.
REQ-016 SHALL, on pop, increment rd_ptr modulo DEPTH and decrement count.
REQ-017 SHALL, on push and pop in the same cycle, perform both; count is unchanged. This rule also applies when full: the byte is accepted and overflow is not set.
REQ-018 SHALL, on push with count == DEPTH and no pop, drop in_data, leave pointers and count unchanged, and set overflow.
REQ-019 SHALL, on push while empty, store the byte, set dout_valid on the next cycle, and ignore dout_ready in the push cycle (no pop).
REQ-020 SHALL drive dout combinationally from the storage entry at rd_ptr; dout is don't-care while dout_valid is low.
REQ-021 SHALL provide 1-cycle latency: in_valid rising in cycle k gives dout_valid high in cycle k+1 when the queue was previously empty.
REQ-022 SHALL derive dout_valid = (count != 0) and full = (count == DEPTH) from registered count, with no extra cycle of lag.
REQ-023 SHALL give ovf_clr priority over a same-cycle overflow set, clearing the flag.
REQ-024 SHALL wrap pointers silently at DEPTH-1 -> 0, with no bubble or lost entry.

Reset
REQ-025 SHALL, while rst is high, force wr_ptr=0, rd_ptr=0, count=0, overflow=0 and in_valid_q=1; therefore dout_valid=0 and full=0.
REQ-026 SHALL NOT write a byte when in_valid is already high at reset release, because in_valid_q resets high; a rising edge after release is required.
REQ-027 SHALL discard all queued bytes when rst is asserted mid-operation; storage contents need not be cleared.

Verification
REQ-028 SHALL pass this scenario: in_valid pulses for 2 cycles with in_data=0x55 -> count=1, dout=0x55, dout_valid=1 one cycle after the edge; dout_ready=1 -> count=0.
REQ-029 SHALL pass this scenario: 16 edges with bytes 0x00..0x0F and dout_ready=0 -> full=1, count=16; a 17th edge with 0xAA -> overflow=1, count=16; drain -> reads 0x00..0x0F in order, 0xAA absent.
REQ-030 SHALL pass this scenario: full queue, push 0xBB with dout_ready=1 in the same cycle -> count stays 16, overflow=0, 0xBB is the last byte read.
REQ-031 SHALL pass this scenario: 40 bytes streamed with continuous dout_ready=1 -> all 40 read in order across pointer wrap, count never above 1.
REQ-032 SHALL pass this scenario: in_valid held high through rst deassertion -> count stays 0; in_valid low then high -> one write.
REQ-033 SHALL pass this scenario: overflow set, then ovf_clr and a dropped push in the same cycle -> overflow=0 next cycle; rst mid-stream with count=5 -> count=0 and dout_valid=0 immediately.
